regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port general-purpose register file for the pipelined CPU core; successor to the single-cycle 2-read/1-write file. It provides NUM_RD read ports and two prioritised write ports, with write-to-read bypass and a per-register busy scoreboard for interlocking. It sits between the decode stage (reads, issue) and the writeback stage (writes), with register 0 hardwired to zero.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register address width; the file holds DEPTH = 2**ADDR_W registers.
- NUM_RD, 2: number of read ports, at least 1.
- BYPASS, 1: 1 = a same-cycle write is forwarded to the reads; 0 = reads return stored contents only.
- CLK  in  1  the single clock; all state updates on its rising edge.
- RST  in  1  reset, asynchronous and active-low.
- RegWre0 / WriteReg0 / WriteData0  in  1 / ADDR_W / DATA_W  write port 0: enable, address, data.
- RegWre1 / WriteReg1 / WriteData1  in  1 / ADDR_W / DATA_W  write port 1: enable, address, data; has priority over port 0.
- ReadReg  in  NUM_RD*ADDR_W  packed read addresses; port k is bits [k*ADDR_W +: ADDR_W].
- ReadData  out  NUM_RD*DATA_W  packed read data, combinational.
- RdBusy  out  NUM_RD  per read port: 1 = the addressed register has a pending producer.
- IssueWre  in  1  marks register IssueReg as busy, meaning a producer is in flight.
- IssueReg  in  ADDR_W  register to mark.
- Flush  in  1  synchronous clear of all busy bits (pipeline flush).
- BusyCount  out  ADDR_W+1  registered count of registers currently busy.

## Operation
- Storage: registers 1..DEPTH-1 hold DATA_W bits. Register 0 does not exist as state.
- Write: on the rising CLK edge, port p writes WriteDatap into WriteRegp when RegWrep=1 and WriteRegp≠0.
- Write collision: both ports enabled with the same nonzero address means only port 1's data is stored.
- Read, port k:
  - address 0 returns 0.
  - If BYPASS=1 and a write port is enabled to the same nonzero address in this cycle, the port returns that write's data (port 1 if both ports match).
  - Otherwise the port returns the stored value.
- Busy bits busy[1..DEPTH-1]; busy[0] is constant 0. Per rising edge, in decreasing priority:
  - Flush=1: all busy bits are cleared, and IssueWre in the same cycle is ignored.
  - IssueWre=1 with IssueReg≠0: busy[IssueReg] is set. This wins over a same-cycle write to the same register, because the new producer supersedes the retiring one.
  - Any enabled write to a nonzero address clears that register's busy bit.
- RdBusy[k] = busy[ReadReg port k], taken from the registered bits. If BYPASS=1 and a same-cycle write targets the same register while IssueWre does not target it, RdBusy[k] is forced to 0 because the value is forwarded.
- BusyCount equals the number of set busy bits after the edge, from 0 to DEPTH-1. It is registered and updates together with the busy bits.
- Writes are accepted whether or not the target register is busy. The scoreboard is advisory and stalling is done by the decode stage.

## Timing
- Reset (RST=0, asynchronous):
  - all registers are 0, all busy bits are 0, BusyCount=0.
  - The outputs follow immediately: every ReadData lane is 0 and RdBusy=0.
- Reset deasserting mid-operation: state is restored on the first rising edge at which RST=1.
- Write latency: 1 edge to storage. Read-after-write in the same cycle gives the new value with BYPASS=1 and the old value with BYPASS=0. From the cycle after the edge, every read sees the new value.
- Issue → RdBusy=1 from the cycle after the edge. Write → RdBusy=0 from the cycle after the edge, or in the same cycle via the bypass rule.
- There is no handshake. All inputs are sampled at the edge and reads are purely combinational from the address inputs.

## Test plan
- Reset: pulse RST low mid-cycle after writing r5=0x1234 → ReadData=0, RdBusy=0 and BusyCount=0 immediately, without waiting for a clock edge.
- Write/read/zero:
  - write r7=0xDEADBEEF via port 0, then read r7 on all NUM_RD ports → 0xDEADBEEF.
  - write r0=0xFFFFFFFF, then read r0 → 0.
- Collision and bypass:
  - same cycle: port 0 writes r3=0x11 and port 1 writes r3=0x22. With BYPASS=1 a read of r3 in that cycle shows 0x22; next cycle stored r3=0x22.
  - repeat with BYPASS=0 → 0x22 is shown only from the next cycle.
- Scoreboard:
  - issue r9, then the next cycle → RdBusy=1 for r9 and BusyCount=1.
  - write r9=0x5 → RdBusy=0 in that cycle (BYPASS=1); next cycle BusyCount=0.
  - issue r4 and write r4 in the same cycle → r4 stays busy and BusyCount=1.
- Flush: issue r1, r2 and r31 over 3 cycles (BusyCount=3), then Flush=1 together with IssueWre on r6 → next cycle BusyCount=0 and r6 is not busy.
- Parameter sweep: DATA_W=64, ADDR_W=4, NUM_RD=4 → random writes/reads checked against a reference model for 10k cycles, including address 0 and collisions.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports, write-to-read bypass
// and a per-register busy scoreboard. Register 0 reads as zero and holds no state.
module regfile_mp #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned BYPASS = 1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       RegWre0,
   input  logic [ADDR_W-1:0]          WriteReg0,
   input  logic [DATA_W-1:0]          WriteData0,
   input  logic                       RegWre1,
   input  logic [ADDR_W-1:0]          WriteReg1,
   input  logic [DATA_W-1:0]          WriteData1,
   input  logic [NUM_RD*ADDR_W-1:0]   ReadReg,
   output logic [NUM_RD*DATA_W-1:0]   ReadData,
   output logic [NUM_RD-1:0]          RdBusy,
   input  logic                       IssueWre,
   input  logic [ADDR_W-1:0]          IssueReg,
   input  logic                       Flush,
   output logic [ADDR_W:0]            BusyCount
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam bit          bypassEn = (BYPASS != 0);

   logic [DEPTH-1:0][DATA_W-1:0] regView;
   logic [DEPTH-1:0]             busyView;
   logic [DEPTH-1:0]             busyNext;
   logic [CNT_W-1:0]             busyCount;

   assign regView[0]  = '0;
   assign busyView[0] = 1'b0;
   assign busyNext[0] = 1'b0;

   // One storage word and one busy flop per architectural register 1..DEPTH-1
   for (genvar i = 1; i < DEPTH; i++) begin : gReg
      logic              wrHit0;
      logic              wrHit1;
      logic              issueHit;
      logic [DATA_W-1:0] q;
      logic              busyQ;

      assign wrHit0   = RegWre0 && (WriteReg0 == ADDR_W'(i));
      assign wrHit1   = RegWre1 && (WriteReg1 == ADDR_W'(i));
      assign issueHit = IssueWre && (IssueReg == ADDR_W'(i));

      // A new producer supersedes a retiring one; flush beats both
      assign busyNext[i] = Flush    ? 1'b0 :
                           issueHit ? 1'b1 :
                           (wrHit0 || wrHit1) ? 1'b0 : busyQ;

      always_ff @(posedge CLK or negedge RST) begin
         if (!RST) begin
            q     <= '0;
            busyQ <= 1'b0;
         end else begin
            if (wrHit1) begin
               q <= WriteData1;
            end else if (wrHit0) begin
               q <= WriteData0;
            end
            busyQ <= busyNext[i];
         end
      end

      assign regView[i]  = q;
      assign busyView[i] = busyQ;
   end

   // Count tracks the post-edge busy set so it updates with the bits themselves
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         busyCount <= '0;
      end else begin
         busyCount <= CNT_W'($countones(busyNext));
      end
   end

   assign BusyCount = busyCount;

   for (genvar k = 0; k < NUM_RD; k++) begin : gRd
      logic [ADDR_W-1:0] ra;
      logic              byp0;
      logic              byp1;
      logic              issueMatch;

      assign ra = ReadReg[k*ADDR_W +: ADDR_W];

      // Forwarding is suppressed in reset so every lane reads zero immediately
      assign byp0 = bypassEn && RST && RegWre0 && (WriteReg0 == ra) && (ra != '0);
      assign byp1 = bypassEn && RST && RegWre1 && (WriteReg1 == ra) && (ra != '0);
      assign issueMatch = IssueWre && (IssueReg == ra);

      assign ReadData[k*DATA_W +: DATA_W] = byp1 ? WriteData1 :
                                            byp0 ? WriteData0 : regView[ra];
      assign RdBusy[k] = busyView[ra] && !((byp0 || byp1) && !issueMatch);
   end

endmodule
